// File: rtl/l2_cache_read_pipe_if.sv
// Bundle of tag-stage request, data SRAM write port, update strobes and registered response
// for the L2 read stage.
interface l2_cache_read_pipe_if #(
   parameter int WAYS      = 8,
   parameter int SETS      = 256,
   parameter int TAG_BITS  = 18,
   parameter int LINE_BITS = 512,
   parameter int THREADS   = 16
);
   localparam int WI = $clog2(WAYS);
   localparam int SI = $clog2(SETS);
   localparam int TI = $clog2(THREADS);

   logic                     t_valid;
   logic [2:0]               t_type;
   logic [TI-1:0]            t_thread;
   logic [TAG_BITS-1:0]      t_tag;
   logic [SI-1:0]            t_set;
   logic [WAYS-1:0]          t_way_valid;
   logic [WAYS-1:0]          t_way_dirty;
   logic [WAYS*TAG_BITS-1:0] t_way_tag;
   logic                     t_is_fill;
   logic [WI-1:0]            t_fill_way;

   logic                     w_en;
   logic [WI+SI-1:0]         w_addr;
   logic [LINE_BITS-1:0]     w_data;

   logic [WAYS-1:0]          upd_dirty_en;
   logic [WAYS-1:0]          upd_tag_en;
   logic [SI-1:0]            upd_set;
   logic                     upd_dirty_value;
   logic                     upd_tag_valid;
   logic [TAG_BITS-1:0]      upd_tag_value;
   logic                     upd_lru_en;
   logic [WI-1:0]            upd_lru_way;

   logic                     r_valid;
   logic [2:0]               r_type;
   logic [TI-1:0]            r_thread;
   logic [TAG_BITS-1:0]      r_tag;
   logic [SI-1:0]            r_set;
   logic                     r_cache_hit;
   logic                     r_is_fill;
   logic                     r_sync_success;
   logic                     r_needs_writeback;
   logic [WI+SI-1:0]         r_hit_idx;
   logic [TAG_BITS-1:0]      r_writeback_tag;
   logic [LINE_BITS-1:0]     r_data;

   logic                     perf_hit;
   logic                     perf_miss;

   modport master (
      output t_valid, t_type, t_thread, t_tag, t_set, t_way_valid, t_way_dirty, t_way_tag,
             t_is_fill, t_fill_way, w_en, w_addr, w_data,
      input  upd_dirty_en, upd_tag_en, upd_set, upd_dirty_value, upd_tag_valid, upd_tag_value,
             upd_lru_en, upd_lru_way, r_valid, r_type, r_thread, r_tag, r_set, r_cache_hit,
             r_is_fill, r_sync_success, r_needs_writeback, r_hit_idx, r_writeback_tag, r_data,
             perf_hit, perf_miss
   );

   modport slave (
      input  t_valid, t_type, t_thread, t_tag, t_set, t_way_valid, t_way_dirty, t_way_tag,
             t_is_fill, t_fill_way, w_en, w_addr, w_data,
      output upd_dirty_en, upd_tag_en, upd_set, upd_dirty_value, upd_tag_valid, upd_tag_value,
             upd_lru_en, upd_lru_way, r_valid, r_type, r_thread, r_tag, r_set, r_cache_hit,
             r_is_fill, r_sync_success, r_needs_writeback, r_hit_idx, r_writeback_tag, r_data,
             perf_hit, perf_miss
   );
endinterface

// File: rtl/l2_cache_read_pipe.sv
// L2 read stage: way-hit resolve, data SRAM read, tag-stage update strobes, sync reservations.
// Define L2_SYNC_TIMEOUT_EN to give each reservation a SYNC_TIMEOUT-cycle lifetime.
module l2_cache_read_pipe #(
   parameter int WAYS         = 8,
   parameter int SETS         = 256,
   parameter int TAG_BITS     = 18,
   parameter int LINE_BITS    = 512,
   parameter int THREADS      = 16,
   parameter int SYNC_TIMEOUT = 1024
) (
   input logic              clk,
   input logic              reset,
   l2_cache_read_pipe_if.slave bus
);
   localparam int WI = $clog2(WAYS);
   localparam int SI = $clog2(SETS);
   localparam int TI = $clog2(THREADS);
   localparam int AW = TAG_BITS + SI;

   localparam logic [2:0] T_LOAD       = 3'd0;
   localparam logic [2:0] T_STORE      = 3'd1;
   localparam logic [2:0] T_FLUSH      = 3'd2;
   localparam logic [2:0] T_INVALIDATE = 3'd3;
   localparam logic [2:0] T_LOAD_SYNC  = 3'd4;
   localparam logic [2:0] T_STORE_SYNC = 3'd5;

   logic [WAYS-1:0]      hit_oh;
   logic [WI-1:0]        hit_way;
   logic                 hit;
   logic [WI-1:0]        read_way;
   logic [WI-1:0]        wb_way;
   logic [WAYS-1:0]      fill_oh;
   logic                 is_store;
   logic                 is_flush;
   logic                 is_inval;
   logic                 act;
   logic [WI+SI-1:0]     rd_addr;
   logic [AW-1:0]        req_addr;
   logic                 can_sync;
   logic                 do_set;
   logic                 do_clear;
   logic [THREADS-1:0]   set_vec;
   logic [THREADS-1:0]   clr_vec;
   logic [THREADS-1:0]   expire;
   logic [THREADS-1:0]   res_valid;
   logic [AW-1:0]        res_addr [THREADS];
   logic [LINE_BITS-1:0] mem [WAYS*SETS];

   always_comb begin
      hit_oh  = '0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         hit_oh[w] = bus.t_way_valid[w] && (bus.t_way_tag[w*TAG_BITS +: TAG_BITS] == bus.t_tag);
         if (hit_oh[w]) hit_way = hit_way | WI'(w);
      end
   end

   assign hit      = bus.t_valid && (|hit_oh);
   assign read_way = bus.t_is_fill ? bus.t_fill_way : hit_way;
   assign fill_oh  = WAYS'(1) << bus.t_fill_way;
   assign is_store = (bus.t_type == T_STORE) || (bus.t_type == T_STORE_SYNC);
   assign is_flush = (bus.t_type == T_FLUSH);
   assign is_inval = (bus.t_type == T_INVALIDATE);
   assign act      = bus.t_valid && (hit || bus.t_is_fill);
   assign rd_addr  = {read_way, bus.t_set};
   assign wb_way   = (is_flush || is_inval) ? hit_way : bus.t_fill_way;

   always_comb begin
      bus.upd_dirty_en = '0;
      bus.upd_tag_en   = '0;
      if (bus.t_valid && bus.t_is_fill) begin
         bus.upd_dirty_en = fill_oh;
         bus.upd_tag_en   = fill_oh;
      end else if (hit) begin
         if (is_store || is_flush) bus.upd_dirty_en = hit_oh;
         if (is_inval)             bus.upd_tag_en   = hit_oh;
      end
   end

   assign bus.upd_set         = bus.t_set;
   assign bus.upd_dirty_value = is_store;
   assign bus.upd_tag_valid   = !is_inval;
   assign bus.upd_tag_value   = bus.t_tag;
   assign bus.upd_lru_en      = hit && !is_flush && !is_inval;
   assign bus.upd_lru_way     = hit_way;

   assign bus.perf_hit  = bus.t_valid && !bus.t_is_fill &&
                          ((bus.t_type == T_LOAD) || (bus.t_type == T_STORE)) && hit;
   assign bus.perf_miss = bus.t_valid && !bus.t_is_fill &&
                          ((bus.t_type == T_LOAD) || (bus.t_type == T_STORE)) && !hit;

   always_ff @(posedge clk) begin
      if (bus.w_en) mem[bus.w_addr] <= bus.w_data;
   end

   // Bypass keeps a same-cycle write to the read index visible to the reader.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.r_data <= '0;
      end else if (act) begin
         bus.r_data <= (bus.w_en && (bus.w_addr == rd_addr)) ? bus.w_data : mem[rd_addr];
      end
   end

   assign req_addr = {bus.t_tag, bus.t_set};
   assign can_sync = (bus.t_type == T_STORE_SYNC) && res_valid[bus.t_thread] &&
                     (res_addr[bus.t_thread] == req_addr);
   assign do_set   = act && (bus.t_type == T_LOAD_SYNC);
   // A failed STORE_SYNC leaves other reservations intact so competing threads cannot livelock.
   assign do_clear = act && ((bus.t_type == T_STORE) || is_inval ||
                             ((bus.t_type == T_STORE_SYNC) && can_sync));

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      for (int i = 0; i < THREADS; i++) begin
         set_vec[i] = do_set && (bus.t_thread == TI'(i));
         clr_vec[i] = do_clear && res_valid[i] && (res_addr[i] == req_addr);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < THREADS; i++) begin
         if (set_vec[i]) res_addr[i] <= req_addr;
      end
   end

`ifdef L2_SYNC_TIMEOUT_EN
   localparam int CW = $clog2(SYNC_TIMEOUT + 1);
   logic [CW-1:0] res_cnt [THREADS];

   always_comb begin
      expire = '0;
      for (int i = 0; i < THREADS; i++) expire[i] = res_valid[i] && (res_cnt[i] == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < THREADS; i++) res_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < THREADS; i++) begin
            if (set_vec[i])                          res_cnt[i] <= CW'(SYNC_TIMEOUT);
            else if (res_valid[i] && res_cnt[i] != '0) res_cnt[i] <= res_cnt[i] - 1'b1;
         end
      end
   end
`else
   assign expire = '0;
`endif

   // Set takes priority over both clear-by-match and expiry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_valid <= '0;
      end else begin
         for (int i = 0; i < THREADS; i++) begin
            if (set_vec[i])                   res_valid[i] <= 1'b1;
            else if (clr_vec[i] || expire[i]) res_valid[i] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.r_valid           <= 1'b0;
         bus.r_type            <= '0;
         bus.r_thread          <= '0;
         bus.r_tag             <= '0;
         bus.r_set             <= '0;
         bus.r_cache_hit       <= 1'b0;
         bus.r_is_fill         <= 1'b0;
         bus.r_sync_success    <= 1'b0;
         bus.r_needs_writeback <= 1'b0;
         bus.r_hit_idx         <= '0;
         bus.r_writeback_tag   <= '0;
      end else begin
         bus.r_valid           <= bus.t_valid;
         bus.r_type            <= bus.t_type;
         bus.r_thread          <= bus.t_thread;
         bus.r_tag             <= bus.t_tag;
         bus.r_set             <= bus.t_set;
         bus.r_cache_hit       <= hit;
         bus.r_is_fill         <= bus.t_is_fill;
         bus.r_sync_success    <= act && can_sync;
         bus.r_needs_writeback <= act && bus.t_way_valid[wb_way] && bus.t_way_dirty[wb_way];
         bus.r_hit_idx         <= rd_addr;
         bus.r_writeback_tag   <= bus.t_way_tag[wb_way*TAG_BITS +: TAG_BITS];
      end
   end

   a_fill_no_hit: assert property (@(posedge clk) disable iff (reset) !(bus.t_is_fill && hit));
   a_hit_onehot:  assert property (@(posedge clk) disable iff (reset)
                                   bus.t_valid |-> $onehot0(hit_oh));

endmodule

// File: doc/l2_cache_read_pipe.md
# l2_cache_read_pipe

Parametrised L2 read stage: sits between the L2 tag stage and the L2 write stage. It resolves way hits, reads line data from a one-read/one-write data SRAM, and drives same-cycle dirty/tag/LRU update strobes back to the tag stage. It tracks per-thread synchronized-load reservations and adds an INVALIDATE request type. It is the generalised successor of the fixed-geometry read stage; ways, sets, tag width, line width and thread count are all parameters.

## Interface
- WAYS, 8, associativity (power of 2, ≥2); WI = $clog2(WAYS)
- SETS, 256, sets per way (power of 2); SI = $clog2(SETS)
- TAG_BITS, 18, tag width
- LINE_BITS, 512, line data width
- THREADS, 16, total hardware threads; TI = $clog2(THREADS)
- SYNC_TIMEOUT, 1024, reservation lifetime in cycles (used only with the timeout macro)
- clk  in  1  clock; all state on posedge
- reset  in  1  asynchronous, active-high
- t_valid  in  1  request valid from tag stage
- t_type  in  3  LOAD=0, STORE=1, FLUSH=2, INVALIDATE=3, LOAD_SYNC=4, STORE_SYNC=5
- t_thread  in  TI  requesting thread
- t_tag / t_set  in  TAG_BITS / SI  request address
- t_way_valid / t_way_dirty  in  WAYS  per-way metadata
- t_way_tag  in  WAYS*TAG_BITS  way w at [w*TAG_BITS +: TAG_BITS]
- t_is_fill / t_fill_way  in  1 / WI  restarted fill and its victim way
- w_en / w_addr / w_data  in  1 / WI+SI / LINE_BITS  data SRAM write port; address is {way,set}
- upd_dirty_en / upd_tag_en  out  WAYS  one-hot strobes; combinational
- upd_set  out  SI  = t_set
- upd_dirty_value / upd_tag_valid  out  1
- upd_tag_value  out  TAG_BITS  = t_tag
- upd_lru_en / upd_lru_way  out  1 / WI
- r_valid, r_type, r_thread, r_tag, r_set  out  registered request copy
- r_cache_hit, r_is_fill, r_sync_success, r_needs_writeback  out  1
- r_hit_idx  out  WI+SI  SRAM index that was read
- r_writeback_tag  out  TAG_BITS
- r_data  out  LINE_BITS  SRAM read data
- perf_hit / perf_miss  out  1  combinational pulses

## Operation
- hit_oh[w] = t_way_valid[w] && tag[w]==t_tag. hit = t_valid && |hit_oh. hit_way is the index of hit_oh.
- read_way = t_is_fill ? t_fill_way : hit_way. The SRAM read is enabled when t_valid && (hit || t_is_fill).
- Dirty update when t_valid && (t_is_fill || hit && type∈{STORE,STORE_SYNC,FLUSH}). The target way is the fill way on a fill, else hit_oh. The value is 1 for a store, else 0.
- Tag update when t_valid && (t_is_fill || hit && INVALIDATE). The target way is the fill way or the hit way. upd_tag_valid = !INVALIDATE.
- upd_lru_en = hit && type∉{FLUSH,INVALIDATE}.
- wb_way = (FLUSH||INVALIDATE) ? hit_way : t_fill_way. r_needs_writeback ← t_valid && (t_is_fill||hit) && valid[wb_way] && dirty[wb_way]. r_writeback_tag ← tag[wb_way].
- Reservations are per thread: addr {tag,set} plus valid bit. They are only acted on when t_valid && (hit || t_is_fill).
  - LOAD_SYNC sets the entry for t_thread.
  - can_sync = STORE_SYNC && the entry for t_thread is valid && its address matches the request.
  - STORE, a successful STORE_SYNC, or INVALIDATE clears every valid entry whose address matches.
  - A failed STORE_SYNC clears nothing; this prevents livelock.
- r_sync_success ← can_sync when the qualifier holds, else 0.
- perf_hit / perf_miss = t_valid && !t_is_fill && type∈{LOAD,STORE} && hit / !hit.

## Timing
- All r_* outputs are registered, with 1-cycle latency. r_data is valid in the same cycle as r_valid.
- SRAM read-during-write to the same index returns the new data.
- Reset values: all r_* = 0, all reservation valid bits = 0, and timeout counters = 0. Reservation addresses need not be reset.
- Same-cycle LOAD_SYNC set and clear-by-match on one entry cannot happen, because each request is a single type.
- An asserted reset mid-stream drops the in-flight request. r_valid is 0 on the first cycle after reset deasserts.
- The following are illegal and are flagged by simulation assertions:
  - t_is_fill && hit
  - more than one bit set in hit_oh

## Configuration
- L2_SYNC_TIMEOUT_EN defined:
  - Each thread has a counter of $clog2(SYNC_TIMEOUT+1) bits.
  - LOAD_SYNC loads the counter with SYNC_TIMEOUT.
  - The counter decrements each cycle while its entry is valid. When it reaches 0, the valid bit clears on the next edge.
  - If a set and an expiry hit the same thread in one cycle, the set wins.
  - can_sync uses the valid bit as it stood before the edge.
- L2_SYNC_TIMEOUT_EN undefined: there are no counters and reservations persist until cleared.

## Test plan
- Hit: way 3 tag 0x155, LOAD set 7 → r_cache_hit=1, r_hit_idx={3,7}, r_data equals the written line, upd_lru_way=3, perf_hit=1.
- Fill: victim way 2 is dirty with tag 0xAA → upd_tag_en=0b100 with tag t_tag, r_needs_writeback=1, r_writeback_tag=0xAA.
- INVALIDATE hit on a dirty way 5 → upd_tag_valid=0, r_needs_writeback=1, no LRU update, and matching reservations cleared.
- Sync: thread 4 LOAD_SYNC A, thread 9 STORE A, then thread 4 STORE_SYNC A → r_sync_success=0. Repeated without the intervening store → 1.
- Timeout (SYNC_TIMEOUT=4): LOAD_SYNC, then STORE_SYNC 6 cycles later → 0. STORE_SYNC 3 cycles later → 1.
- Reset is asserted while r_valid=1 → all outputs 0 asynchronously, and a prior reservation does not yield success.
